// File: rtl/intadd_arb.sv
// intadd_arb: round-robin arbiter and sequencer for one shared add32 SIMD adder.
// Each accepted operation goes through three cycles: IDLE (grant and operand
// capture), EXEC (the adder settles on the registered operands) and RESP (the
// captured result is held until the consumer takes it).

module intadd_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*128-1:0] req_src0,
    input  logic [NREQ*128-1:0] req_src1,
    input  logic [NREQ-1:0]    req_sign_s0,
    input  logic [NREQ-1:0]    req_sign_s1,
    output logic [127:0]       add_src0,
    output logic [127:0]       add_src1,
    output logic               add_sign_s0,
    output logic               add_sign_s1,
    input  logic [127:0]       add_dst,
    input  logic [127:0]       add_st,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [127:0]       rsp_dst,
    output logic [127:0]       rsp_st,
    output logic               busy,
    output logic [CNTW-1:0]    done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_ptr_nxt;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     gnt_off;
    logic               gnt_found;
    logic [2*NREQ-1:0]  valid_dbl;
    logic [NREQ-1:0]    valid_rot;
    logic [IDW:0]       gnt_sum;
    logic [127:0]       sel_src0;
    logic [127:0]       sel_src1;
    logic               sel_sign_s0;
    logic               sel_sign_s1;

    // Round-robin search: rotate req_valid so rr_ptr sits at bit 0, take the
    // lowest set bit, then rotate the offset back into a requester index.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_found = 1'b0;
        gnt_off   = '0;
        valid_dbl = {req_valid, req_valid} >> rr_ptr;
        valid_rot = valid_dbl[NREQ-1:0];
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                gnt_found = 1'b1;
                gnt_off   = IDW'(i);
            end
        end
        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        if (gnt_sum >= (IDW+1)'(NREQ)) begin
            gnt_sum = gnt_sum - (IDW+1)'(NREQ);
        end
        gnt_idx = gnt_sum[IDW-1:0];
        if (gnt_idx == IDW'(NREQ - 1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = gnt_idx + IDW'(1);
        end
    end

    // Payload mux: pick the granted requester's operands and sign flags.
    always_comb begin
        sel_src0    = '0;
        sel_src1    = '0;
        sel_sign_s0 = 1'b0;
        sel_sign_s1 = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                sel_src0    = req_src0[k*128 +: 128];
                sel_src1    = req_src1[k*128 +: 128];
                sel_sign_s0 = req_sign_s0[k];
                sel_sign_s1 = req_sign_s1[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: grant moves to EXEC, EXEC always lasts one cycle,
    // RESP waits for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: one-hot accept in IDLE only, busy otherwise.
    always_comb begin
        busy      = (state != IDLE);
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = (state == IDLE) && gnt_found && (gnt_idx == IDW'(k));
        end
    end

    // Datapath registers: operand capture on accept, result capture at the end
    // of EXEC, completion count on the response handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            add_src0    <= '0;
            add_src1    <= '0;
            add_sign_s0 <= 1'b0;
            add_sign_s1 <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_dst     <= '0;
            rsp_st      <= '0;
            done_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        add_src0    <= sel_src0;
                        add_src1    <= sel_src1;
                        add_sign_s0 <= sel_sign_s0;
                        add_sign_s1 <= sel_sign_s1;
                        rsp_id      <= gnt_idx;
                        rr_ptr      <= rr_ptr_nxt;
                    end
                end
                EXEC: begin
                    rsp_dst   <= add_dst;
                    rsp_st    <= add_st;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNTW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
